instruction_encoder: RTL
========================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter FILL_BYTE, default 8'h20, byte emitted for the "other" token (bit 8).
REQ-003 Port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Port RESET  input  1  reset, asynchronous, active-high.
REQ-005 Port IN_VALID  input  1  producer offers IN_DECODED this cycle.
REQ-006 Port IN_READY  output  1  encoder can accept a token this cycle.
REQ-007 Port IN_DECODED  input  9  one-hot token, same bit map as the instruction decoder (bit0 '>' ... bit7 ']', bit8 other).
REQ-008 Port OUT_VALID  output  1  OUT_BYTE holds a valid opcode byte.
REQ-009 Port OUT_READY  input  1  consumer takes OUT_BYTE this cycle.
REQ-010 Port OUT_BYTE  output  8  ASCII opcode byte at FIFO head.
REQ-011 Port ERROR  output  1  sticky flag: an illegal token was offered and accepted.
REQ-012 Port COUNT  output  16  number of bytes delivered on the output since reset/clear.
REQ-013 Port CLEAR  input  1  synchronous clear of ERROR and COUNT.

Function
REQ-014 Input handshake completes on a rising edge with IN_VALID=1 and IN_READY=1; output handshake completes on a rising edge with OUT_VALID=1 and OUT_READY=1.
REQ-015 IN_READY shall equal (occupancy < DEPTH), derived from registered state only, never from IN_VALID or OUT_READY.
REQ-016 OUT_VALID shall equal (occupancy > 0); OUT_BYTE shall be the oldest entry, held stable while OUT_VALID=1 and OUT_READY=0.
REQ-017 Encoding: bit0->8'h3E, bit1->8'h3C, bit2->8'h2B, bit3->8'h2D, bit4->8'h2E, bit5->8'h2C, bit6->8'h5B, bit7->8'h5D, bit8->FILL_BYTE.
REQ-018 A token with exactly one bit set is legal and is pushed as its encoded byte.
REQ-019 A token with zero bits or more than one bit set is illegal: handshake still completes, nothing is pushed, ERROR sets on that edge.
REQ-020 Latency: a legal token accepted at edge N into an empty FIFO shall give OUT_VALID=1 with its byte in the cycle after edge N.
REQ-021 Byte order on the output shall equal acceptance order; no byte lost or duplicated.
REQ-022 Occupancy: +1 on legal push only, -1 on pop only, unchanged on simultaneous legal push and pop.
REQ-023 Full boundary: at occupancy DEPTH, IN_READY=0 and no push occurs; a same-cycle pop frees the slot for the next cycle only.
REQ-024 Empty boundary: at occupancy 0, OUT_VALID=0 and OUT_READY is ignored; OUT_BYTE is don't-care.
REQ-025 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy is log2(DEPTH)+1 bits.
REQ-026 COUNT increments by 1 on each output handshake and wraps 16'hFFFF -> 16'h0000.
REQ-027 CLEAR=1 forces COUNT to 0 on that edge, overriding a same-cycle increment.
REQ-028 CLEAR=1 clears ERROR unless an illegal token is accepted on the same edge; setting wins.
REQ-029 CLEAR does not affect FIFO contents, pointers or handshakes.

Reset
REQ-030 RESET=1 shall asynchronously force occupancy, pointers, COUNT to 0 and ERROR to 0; thus IN_READY=1, OUT_VALID=0.
REQ-031 RESET mid-operation shall discard all buffered bytes; no handshake completes on an edge where RESET=1.
REQ-032 FIFO storage array need not be reset.

Structure
REQ-033 Opcode byte constants (8'h3E ... 8'h5D) and one-hot bit-index constants shall live in the shared pack.v header, used by both decoder and encoder.
REQ-034 FILL_BYTE default stays local to this module.
REQ-035 Storage shall be one sub-module, EncoderFifo (parameterised width 8, DEPTH), with push/pop/full/empty; encoding, legality check, ERROR and COUNT stay in instruction_encoder.

Verification
REQ-036 Reset, then push bit2 (9'h004), OUT_READY=1 -> next cycle OUT_VALID=1, OUT_BYTE=8'h2B; COUNT=1 after pop.
REQ-037 OUT_READY=0, push 9'h001,9'h002,9'h040,9'h080,9'h100 -> IN_READY=0 after 4th; release OUT_READY -> bytes 3E,3C,5B,5D then 20 in order.
REQ-038 Push 9'h000 then 9'h003 -> no bytes emitted, ERROR=1; CLEAR pulse -> ERROR=0, COUNT=0.
REQ-039 At occupancy 4, IN_VALID=1 and OUT_READY=1 same cycle -> one pop, no push, occupancy 3, next cycle push accepted.
REQ-040 Preload COUNT to 16'hFFFF via 65535 pops, one more pop -> COUNT=0; CLEAR with pop same edge -> COUNT=0.
REQ-041 Assert RESET with 3 bytes buffered -> OUT_VALID=0 and IN_READY=1 immediately, no stale byte after release.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// Shared opcode bytes and one-hot token bit positions used by the
// instruction decoder and the instruction encoder.
package instruction_encoder_pkg;

  localparam int TOK_W = 9;

  typedef logic [TOK_W-1:0] token_t;

  // One-hot bit index of each token in the decoded word
  localparam int BIT_GT    = 0;
  localparam int BIT_LT    = 1;
  localparam int BIT_PLUS  = 2;
  localparam int BIT_MINUS = 3;
  localparam int BIT_DOT   = 4;
  localparam int BIT_COMMA = 5;
  localparam int BIT_LBRK  = 6;
  localparam int BIT_RBRK  = 7;
  localparam int BIT_OTHER = 8;

  // ASCII opcode bytes
  localparam logic [7:0] OP_GT    = 8'h3E;
  localparam logic [7:0] OP_LT    = 8'h3C;
  localparam logic [7:0] OP_PLUS  = 8'h2B;
  localparam logic [7:0] OP_MINUS = 8'h2D;
  localparam logic [7:0] OP_DOT   = 8'h2E;
  localparam logic [7:0] OP_COMMA = 8'h2C;
  localparam logic [7:0] OP_LBRK  = 8'h5B;
  localparam logic [7:0] OP_RBRK  = 8'h5D;

endpackage

// File: rtl/instruction_encoder_fifo.sv
// EncoderFifo: circular byte buffer with push/pop and full/empty flags.
// Head entry is presented combinationally on dout.
module EncoderFifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_OCC = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (occ == DEPTH_OCC);
  assign empty   = (occ == '0);
  // Guard internally so a push into a full buffer or a pop from an empty one is a no-op
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents are left unreset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: turns one-hot decoded tokens back into ASCII opcode
// bytes, buffers them in a small FIFO, flags illegal tokens and counts
// delivered bytes.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] FILL_BYTE = 8'h20
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [8:0]   IN_DECODED,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [7:0]   OUT_BYTE,
  output logic         ERROR,
  output logic [15:0]  COUNT,
  input  logic         CLEAR
);

  logic       full;
  logic       empty;
  logic       accept;
  logic       legal;
  logic       push;
  logic       pop;
  logic [7:0] enc_byte;

  function automatic logic [7:0] encode(input token_t tok);
    logic [7:0] b;
    b = FILL_BYTE;
    if      (tok[BIT_GT])    b = OP_GT;
    else if (tok[BIT_LT])    b = OP_LT;
    else if (tok[BIT_PLUS])  b = OP_PLUS;
    else if (tok[BIT_MINUS]) b = OP_MINUS;
    else if (tok[BIT_DOT])   b = OP_DOT;
    else if (tok[BIT_COMMA]) b = OP_COMMA;
    else if (tok[BIT_LBRK])  b = OP_LBRK;
    else if (tok[BIT_RBRK])  b = OP_RBRK;
    else if (tok[BIT_OTHER]) b = FILL_BYTE;
    return b;
  endfunction

  // Ready/valid come from registered occupancy only
  assign IN_READY  = !full;
  assign OUT_VALID = !empty;
  assign accept    = IN_VALID && IN_READY;
  assign legal     = $onehot(IN_DECODED);
  assign push      = accept && legal;
  assign pop       = OUT_VALID && OUT_READY;
  assign enc_byte  = encode(IN_DECODED);

  EncoderFifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .din   (enc_byte),
    .pop   (pop),
    .dout  (OUT_BYTE),
    .full  (full),
    .empty (empty)
  );

  // Sticky error: an accepted illegal token wins over a same-edge clear
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                 ERROR <= 1'b0;
    else if (accept && !legal) ERROR <= 1'b1;
    else if (CLEAR)            ERROR <= 1'b0;
  end

  // Delivered-byte counter: clear overrides a same-edge increment, wraps at 16 bits
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)      COUNT <= '0;
    else if (CLEAR) COUNT <= '0;
    else if (pop)   COUNT <= COUNT + 16'd1;
  end

endmodule
